// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants for the common data bus arbiter.
// Source ports are in fixed producer order.
package cdb_pkg;

  localparam int N_SRC  = 8;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  localparam int TAG_NONE = 0;

  localparam int SRC_ADD1  = 0;
  localparam int SRC_ADD2  = 1;
  localparam int SRC_ADD3  = 2;
  localparam int SRC_MUL1  = 3;
  localparam int SRC_MUL2  = 4;
  localparam int SRC_LD1   = 5;
  localparam int SRC_LD2   = 6;
  localparam int SRC_SPARE = 7;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select over a request vector.
// Search starts at ptr and wraps; first set bit wins.
module rr_picker #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  full,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // walk from ptr upward, wrapping, and stop at the first full slot
  always_comb begin
    int          s;
    logic [IW-1:0] k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      k = IW'(s);
      if (!any && full[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer holding slots feeding one registered
// round-robin broadcast on the common data bus.
module cdb_arbiter
  import cdb_pkg::TAG_NONE;
#(
  parameter int N_SRC  = cdb_pkg::N_SRC,
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int DATA_W = cdb_pkg::DATA_W,
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int PW = $clog2(N_SRC) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*TAG_W-1:0]  req_tag,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  output logic [N_SRC-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [IW-1:0]           cdb_src,
  output logic [PW-1:0]           pending,
  output logic                    tag0_drop
);

  logic [N_SRC-1:0]  full;
  logic [N_SRC-1:0]  full_nxt;
  logic [TAG_W-1:0]  tag_q  [N_SRC];
  logic [DATA_W-1:0] data_q [N_SRC];

  logic [TAG_W-1:0]  in_tag  [N_SRC];
  logic [DATA_W-1:0] in_data [N_SRC];
  logic [N_SRC-1:0]  store;
  logic [N_SRC-1:0]  zero;

  logic [IW-1:0]     ptr;
  logic [IW-1:0]     ptr_nxt;
  logic [N_SRC-1:0]  grant;
  logic [IW-1:0]     gidx;
  logic              gany;

  rr_picker #(
    .N (N_SRC)
  ) u_pick (
    .full  (full),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // a slot can take a result when empty or when it drains this cycle
  always_comb begin
    req_ready = reset ? '0 : (~full | grant);
  end

  // split the flat request buses and classify accepted requests
  always_comb begin
    store = '0;
    zero  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      in_tag[i]  = req_tag[i*TAG_W +: TAG_W];
      in_data[i] = req_data[i*DATA_W +: DATA_W];
      if (req_valid[i] && req_ready[i]) begin
        if (in_tag[i] == TAG_W'(TAG_NONE)) zero[i] = 1'b1;
        else store[i] = 1'b1;
      end
    end
  end

  // refill wins over grant so a streaming port loses no cycle
  always_comb begin
    full_nxt = full;
    for (int i = 0; i < N_SRC; i++) begin
      if (store[i]) full_nxt[i] = 1'b1;
      else if (grant[i]) full_nxt[i] = 1'b0;
    end
  end

  // next search start is one past the winner
  always_comb begin
    if (gidx == IW'(N_SRC - 1)) ptr_nxt = '0;
    else ptr_nxt = gidx + IW'(1);
  end

  // slot occupancy and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      ptr  <= '0;
    end else begin
      full <= full_nxt;
      if (gany) ptr <= ptr_nxt;
    end
  end

  // slot payload; only written on a stored transfer
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (store[i]) begin
        tag_q[i]  <= in_tag[i];
        data_q[i] <= in_data[i];
      end
    end
  end

  // registered broadcast; payload holds when there is no winner
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= gany;
      if (gany) begin
        cdb_tag  <= tag_q[gidx];
        cdb_data <= data_q[gidx];
        cdb_src  <= gidx;
      end
    end
  end

  // occupancy count and tag-0 discard pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      tag0_drop <= 1'b0;
    end else begin
      pending   <= PW'($countones(full_nxt));
      tag0_drop <= |zero;
    end
  end

endmodule
